// File: rtl/rf_writeback_unit.sv
// rf_writeback_unit: register-file write port arbiter for ALU results and variable-latency loads.
// Optional: RF_WB_LOAD_ERR_EN enables the sticky ld_err flag for unexpected memory responses.
`default_nettype none

module rf_writeback_unit #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_valid,
  output logic         alu_ready,
  input  logic [4:0]   alu_rd,
  input  logic [N-1:0] alu_data,
  input  logic         ld_issue_valid,
  output logic         ld_issue_ready,
  input  logic [4:0]   ld_rd,
  input  logic [2:0]   ld_funct3,
  input  logic [1:0]   ld_addr_lo,
  input  logic         mem_rvalid,
  input  logic [N-1:0] mem_rdata,
  output logic [31:0]  pending_mask,
  output logic         RegWrite,
  output logic [4:0]   WriteReg,
  output logic [N-1:0] WriteData,
  output logic         ld_err
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]   tag_rd_q [DEPTH];
  logic [2:0]   tag_f3_q [DEPTH];
  logic [1:0]   tag_lo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic         skid_full_q, skid_full_d;
  logic [4:0]   skid_rd_q, skid_rd_d;
  logic [N-1:0] skid_data_q, skid_data_d;

  logic         we_q, we_d;
  logic [4:0]   wreg_q, wreg_d;
  logic [N-1:0] wdata_q, wdata_d;

  logic         fifo_empty, fifo_full, push, pop, alu_fire;
  logic [4:0]   head_rd;
  logic [2:0]   head_f3;
  logic [1:0]   head_lo;
  logic [N-1:0] shifted, ld_data;

  assign fifo_empty     = (count_q == '0);
  assign fifo_full      = (count_q == FULL_CNT);
  assign ld_issue_ready = !fifo_full;
  assign alu_ready      = !skid_full_q;
  assign push           = ld_issue_valid && !fifo_full;
  assign pop            = mem_rvalid && !fifo_empty;
  assign alu_fire       = alu_valid && !skid_full_q;

  assign head_rd = tag_rd_q[rd_ptr_q];
  assign head_f3 = tag_f3_q[rd_ptr_q];
  assign head_lo = tag_lo_q[rd_ptr_q];

  always_comb begin
    shifted = mem_rdata >> {head_lo, 3'b000};
    case (head_f3)
      3'b000:  ld_data = {{(N-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{(N-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {{(N-8){1'b0}}, shifted[7:0]};
      3'b101:  ld_data = {{(N-16){1'b0}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [AW-1:0] offset;
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = AW'(i) - rd_ptr_q;
      if ({1'b0, offset} < count_q) begin
        pending_mask[tag_rd_q[i]] = 1'b1;
      end
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_rd_q[wr_ptr_q] <= ld_rd;
      tag_f3_q[wr_ptr_q] <= ld_funct3;
      tag_lo_q[wr_ptr_q] <= ld_addr_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    we_d        = 1'b0;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    skid_full_d = skid_full_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    if (pop) begin
      we_d    = (head_rd != 5'd0);
      wreg_d  = head_rd;
      wdata_d = ld_data;
      if (alu_fire) begin
        skid_full_d = 1'b1;
        skid_rd_d   = alu_rd;
        skid_data_d = alu_data;
      end
    end else if (skid_full_q) begin
      we_d        = (skid_rd_q != 5'd0);
      wreg_d      = skid_rd_q;
      wdata_d     = skid_data_q;
      skid_full_d = 1'b0;
    end else if (alu_valid) begin
      we_d    = (alu_rd != 5'd0);
      wreg_d  = alu_rd;
      wdata_d = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      skid_full_q <= 1'b0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
    end else begin
      we_q        <= we_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      skid_full_q <= skid_full_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign RegWrite  = we_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;

`ifdef RF_WB_LOAD_ERR_EN
  logic ld_err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_err_q <= 1'b0;
    end else if (mem_rvalid && fifo_empty) begin
      ld_err_q <= 1'b1;
    end
  end
  assign ld_err = ld_err_q;
`else
  assign ld_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_unit.sv
// tb_rf_writeback_unit: directed stimulus with a queue-based reference model checked every cycle.
`default_nettype none

module tb_rf_writeback_unit;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alu_valid = 1'b0;
  logic         alu_ready;
  logic [4:0]   alu_rd = '0;
  logic [N-1:0] alu_data = '0;
  logic         ld_issue_valid = 1'b0;
  logic         ld_issue_ready;
  logic [4:0]   ld_rd = '0;
  logic [2:0]   ld_funct3 = '0;
  logic [1:0]   ld_addr_lo = '0;
  logic         mem_rvalid = 1'b0;
  logic [N-1:0] mem_rdata = '0;
  logic [31:0]  pending_mask;
  logic         RegWrite;
  logic [4:0]   WriteReg;
  logic [N-1:0] WriteData;
  logic         ld_err;

  rf_writeback_unit #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .pending_mask(pending_mask),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ld_err(ld_err)
  );

  always #5 clk = ~clk;

`ifdef RF_WB_LOAD_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding loads as a plain queue, skid as a single slot.
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } tag_t;

  tag_t        q[$];
  bit          m_skid_v;
  logic [4:0]  m_skid_rd;
  logic [31:0] m_skid_data;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_err;
  bit          m_rdy_ld, m_alu_acc;
  tag_t        m_t;

  function automatic logic [31:0] m_align(input tag_t t, input logic [31:0] w);
    logic [31:0] s, b, h;
    s = w >> (8 * t.lo);
    b = s % 256;
    h = s % 65536;
    case (t.f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return s;
    endcase
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = 0;
    foreach (q[i]) if (q[i].rd != 0) m = m | (32'd1 << q[i].rd);
    return m;
  endfunction

  task automatic m_emit(input logic [4:0] rd, input logic [31:0] d);
    m_we   = (rd != 0);
    m_rd   = rd;
    m_data = d;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_skid_v = 0;
      m_we = 0; m_rd = 0; m_data = 0; m_err = 0;
    end else begin
      m_rdy_ld  = (q.size() < DEPTH);
      m_alu_acc = alu_valid && !m_skid_v;
      if (mem_rvalid && q.size() > 0) begin
        m_t = q.pop_front();
        m_emit(m_t.rd, m_align(m_t, mem_rdata));
        if (m_alu_acc) begin
          m_skid_v = 1; m_skid_rd = alu_rd; m_skid_data = alu_data;
        end
      end else if (m_skid_v) begin
        m_emit(m_skid_rd, m_skid_data);
        m_skid_v = 0;
      end else if (alu_valid) begin
        m_emit(alu_rd, alu_data);
      end else begin
        m_we = 0;
      end
      if (mem_rvalid && m_rdy_ld && q.size() == 0 && !m_we && ERR_EN) m_err = 1;
      if (ld_issue_valid && m_rdy_ld) q.push_back('{rd: ld_rd, f3: ld_funct3, lo: ld_addr_lo});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("RegWrite", {31'd0, RegWrite}, {31'd0, m_we});
      if (m_we) begin
        check("WriteReg", {27'd0, WriteReg}, {27'd0, m_rd});
        check("WriteData", WriteData, m_data);
      end
      check("alu_ready", {31'd0, alu_ready}, {31'd0, !m_skid_v});
      check("ld_issue_ready", {31'd0, ld_issue_ready}, {31'd0, q.size() < DEPTH});
      check("pending_mask", pending_mask, m_mask());
      check("ld_err", {31'd0, ld_err}, {31'd0, m_err});
    end
  end

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    ld_issue_valid = 1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo;
  endtask

  task automatic lit_wr(input string name, input logic [4:0] rd, input logic [31:0] d);
    check({name, "_we"}, {31'd0, RegWrite}, 32'd1);
    check({name, "_rd"}, {27'd0, WriteReg}, {27'd0, rd});
    check({name, "_data"}, WriteData, d);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk_en = 1;
    check("rst_we", {31'd0, RegWrite}, 32'd0);
    check("rst_rd", {27'd0, WriteReg}, 32'd0);
    check("rst_data", WriteData, 32'd0);
    check("rst_mask", pending_mask, 32'd0);

    // ALU only, three back-to-back
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit_wr("alu", 5'd5, 32'h1234);
      check("alu_ready_hi", {31'd0, alu_ready}, 32'd1);
      if (i == 2) alu_valid = 0;
    end

    // Collision of load response and ALU result
    issue(5'd7, 3'b010, 2'd0);
    @(negedge clk);
    ld_issue_valid = 0;
    check("mask_x7", pending_mask, 32'h80);
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
    @(negedge clk);
    mem_rvalid = 0; alu_valid = 0;
    lit_wr("coll_ld", 5'd7, 32'hDEADBEEF);
    check("coll_ready_lo", {31'd0, alu_ready}, 32'd0);
    check("coll_mask", pending_mask, 32'd0);
    @(negedge clk);
    lit_wr("coll_alu", 5'd3, 32'h11);
    check("coll_ready_hi", {31'd0, alu_ready}, 32'd1);

    // Alignment
    issue(5'd10, 3'b000, 2'd3);
    @(negedge clk);
    issue(5'd11, 3'b101, 2'd2);
    @(negedge clk);
    issue(5'd12, 3'b001, 2'd0);
    @(negedge clk);
    ld_issue_valid = 0;
    mem_rvalid = 1; mem_rdata = 32'h80000000;
    @(negedge clk);
    mem_rdata = 32'hABCD0000;
    lit_wr("lb3", 5'd10, 32'hFFFFFF80);
    @(negedge clk);
    mem_rdata = 32'h00008001;
    lit_wr("lhu2", 5'd11, 32'h0000ABCD);
    @(negedge clk);
    mem_rvalid = 0;
    lit_wr("lh0", 5'd12, 32'hFFFF8001);

    // FIFO full with a duplicated destination
    issue(5'd1, 3'b010, 2'd0);
    @(negedge clk);
    issue(5'd2, 3'b010, 2'd0);
    @(negedge clk);
    issue(5'd2, 3'b010, 2'd0);
    @(negedge clk);
    issue(5'd9, 3'b010, 2'd0);
    @(negedge clk);
    check("full_ready", {31'd0, ld_issue_ready}, 32'd0);
    check("full_mask", pending_mask, 32'h206);
    issue(5'd20, 3'b010, 2'd0);
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    ld_issue_valid = 0;
    check("pop1_mask", pending_mask, 32'h204);
    check("pop1_ready", {31'd0, ld_issue_ready}, 32'd1);
    @(negedge clk);
    check("pop2_mask", pending_mask, 32'h204);
    @(negedge clk);
    check("pop3_mask", pending_mask, 32'h200);
    @(negedge clk);
    mem_rvalid = 0;
    check("pop4_mask", pending_mask, 32'h0);

    // x0 write is suppressed
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h55;
    @(negedge clk);
    alu_valid = 0;
    check("x0_we", {31'd0, RegWrite}, 32'd0);

    // Reset with loads outstanding and an ALU op in flight
    issue(5'd4, 3'b010, 2'd0);
    @(negedge clk);
    issue(5'd6, 3'b010, 2'd0);
    @(negedge clk);
    ld_issue_valid = 0;
    check("pre_rst_mask", pending_mask, 32'h50);
    rst = 1; alu_valid = 1; alu_rd = 5'd8; alu_data = 32'h99;
    @(negedge clk);
    rst = 0; alu_valid = 0;
    check("rst2_mask", pending_mask, 32'd0);
    check("rst2_ready", {31'd0, ld_issue_ready}, 32'd1);
    check("rst2_we", {31'd0, RegWrite}, 32'd0);

    // Unexpected response with empty FIFO
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 0;
    check("unexp_we", {31'd0, RegWrite}, 32'd0);
    check("unexp_err", {31'd0, ld_err}, {31'd0, ERR_EN});
    @(negedge clk);
    check("unexp_err_sticky", {31'd0, ld_err}, {31'd0, ERR_EN});

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
